// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, assembles 11-bit frames and queues scan-code bytes for CPU reads.
// Optional odd-parity frame check is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keyboard #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rdn,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          clk_s1_q, clk_s2_q, clk_s3_q, dat_s1_q, dat_s2_q, rdn_q;
    logic          clk_s1_d, clk_s2_d, clk_s3_d, dat_s1_d, dat_s2_d, rdn_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d, overflow_q, overflow_d;
`ifdef PS2_PARITY_CHECK_EN
    logic          parity_q, parity_d;
`endif

    logic          fall_s, frame_done_s, frame_valid_s, full_s, push_s, pop_s;
    logic [AW-1:0] rd_idx_s;

    function automatic logic odd_parity_ok(input logic [7:0] byte_v, input logic par_v);
        return ^{byte_v, par_v};
    endfunction

    // Next-state logic for synchronisers, frame FSM, timeout and FIFO.
    always_comb begin
        clk_s1_d     = ps2_clk;
        clk_s2_d     = clk_s1_q;
        clk_s3_d     = clk_s2_q;
        dat_s1_d     = ps2_data;
        dat_s2_d     = dat_s1_q;
        rdn_d        = rdn;
        fall_s       = clk_s3_q & ~clk_s2_q;
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        idle_cnt_d   = idle_cnt_q;
        frame_done_s = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            IDLE: begin
                idle_cnt_d = '0;
                if (fall_s && !dat_s2_q) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd0;
                end else begin
                    state_d  = IDLE;
                end
            end
            RECV: begin
                if (fall_s) begin
                    idle_cnt_d = '0;
                    bitcnt_d   = bitcnt_q + 4'd1;
                    if (bitcnt_q < 4'd8) begin
                        shreg_d = {dat_s2_q, shreg_q[7:1]};
                    end else if (bitcnt_q == 4'd8) begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_d = dat_s2_q;
`endif
                    end else begin
                        state_d      = IDLE;
                        frame_done_s = 1'b1;
                    end
                end else if (idle_cnt_q == CW'(TIMEOUT)) begin
                    state_d = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PS2_PARITY_CHECK_EN
        frame_valid_s = frame_done_s & dat_s2_q & odd_parity_ok(shreg_q, parity_q);
`else
        frame_valid_s = frame_done_s & dat_s2_q;
`endif
        // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
        full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_s      = ~rdn & rdn_q & ready_q;
        push_s     = frame_valid_s & (~full_s | pop_s);
        overflow_d = overflow_q | (frame_valid_s & full_s & ~pop_s);
        wr_ptr_d   = push_s ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        rd_idx_s   = rd_ptr_d[AW-1:0];
        ready_d    = (wr_ptr_d != rd_ptr_d);
        if (!ready_d) begin
            data_d = 8'h00;
        end else if (push_s && (wr_ptr_q[AW-1:0] == rd_idx_s)) begin
            data_d = shreg_q;
        end else begin
            data_d = mem_q[rd_idx_s];
        end
    end

    // State register for all control flops; pins idle high, so synchronisers reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_s3_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            rdn_q      <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= 4'd0;
            shreg_q    <= 8'h00;
            idle_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_q     <= 8'h00;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_s3_q   <= clk_s3_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            rdn_q      <= rdn_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            idle_cnt_q <= idle_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // FIFO storage; contents are only visible through the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
        end
    end

    assign data     = data_q;
    assign ready    = ready_q;
    assign overflow = overflow_q;

endmodule
